// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared IF/ID types; IF_MISALIGN_EXC_EN adds the misaligned-fetch flag
package instr_fetch_pkg;

    localparam int XLEN = 32;

`ifdef IF_MISALIGN_EXC_EN
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
`endif

    typedef struct packed {
`ifdef IF_MISALIGN_EXC_EN
        logic exception_instr_misaligned;
`endif
        logic valid;
    } if2id_pipeline_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
    } if2id_pipeline_data_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with occupancy count and clear
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != FULL) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner, pipelined ibus reads and IF/ID register; IF_MISALIGN_EXC_EN enables misaligned-target exceptions
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_stall,
    input  logic                 if_flush,
    input  logic                 branch_take,
    input  logic [XLEN-1:0]      branch_pc,
    input  logic                 trap_take,
    input  logic [XLEN-1:0]      trap_pc,
    output logic                 ibus_read,
    output logic [XLEN-1:0]      ibus_address,
    input  logic                 ibus_waitrequest,
    input  logic                 ibus_readdatavalid,
    input  logic [XLEN-1:0]      ibus_readdata,
    output if2id_pipeline_ctrl_t if2id_pipeline_ctrl,
    output if2id_pipeline_data_t if2id_pipeline_data
);
    localparam int          CW      = $clog2(FETCH_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FETCH_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_head;
    logic [XLEN-1:0] data_head;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   pc_count;
    logic [CW-1:0]   data_count;
    logic            redirect;
    logic            accept;
    logic            resp_live;
    logic            advance;
    logic            take_fifo;
    logic            take_bypass;
    logic            fetch_halt;

    assign redirect   = trap_take | branch_take;
    assign target_raw = trap_take ? trap_pc : branch_pc;

`ifdef IF_MISALIGN_EXC_EN
    logic exc_pending;
    logic exc_take;

    assign target   = target_raw;
    assign exc_take = advance & exc_pending;

    // A misaligned target is reported once, then fetch parks until the next redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_pending <= 1'b0;
            fetch_halt  <= 1'b0;
        end else if (redirect) begin
            exc_pending <= |target[1:0];
            fetch_halt  <= |target[1:0];
        end else if (exc_take) begin
            exc_pending <= 1'b0;
        end
    end
`else
    assign target     = target_raw & ~32'h3;
    assign fetch_halt = 1'b0;
`endif

    // Credits cover requests awaiting a slot in the IF/ID register plus stale ones still to drain.
    assign ibus_read    = ~rst & ~redirect & ~fetch_halt
                        & (({1'b0, pc_count} + {1'b0, drop_cnt}) < CREDITS);
    assign ibus_address = pc_q;
    assign accept       = ibus_read & ~ibus_waitrequest;
    assign resp_live    = ibus_readdatavalid & (drop_cnt == '0);
    assign advance      = ~if_stall & ~if_flush & ~redirect;
    assign take_fifo    = advance & (data_count != '0);
    assign take_bypass  = advance & (data_count == '0) & resp_live;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FETCH_DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (accept),
        .push_data (pc_q),
        .pop       (take_fifo | take_bypass),
        .head      (pc_head),
        .count     (pc_count)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FETCH_DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (resp_live & ~redirect & ~take_bypass),
        .push_data (ibus_readdata),
        .pop       (take_fifo),
        .head      (data_head),
        .count     (data_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= target;
        end else if (accept) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // On redirect every request not yet answered becomes stale; a response landing now consumes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= drop_cnt + pc_count - data_count - CW'(ibus_readdatavalid);
        end else if (ibus_readdatavalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if2id_pipeline_ctrl <= '0;
        end else if (redirect || if_flush) begin
            if2id_pipeline_ctrl <= '0;
        end else if (!if_stall) begin
`ifdef IF_MISALIGN_EXC_EN
            if2id_pipeline_ctrl.valid                      <= take_fifo | take_bypass | exc_take;
            if2id_pipeline_ctrl.exception_instr_misaligned <= exc_take;
`else
            if2id_pipeline_ctrl.valid <= take_fifo | take_bypass;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (take_fifo) begin
            if2id_pipeline_data <= {data_head, pc_head};
        end else if (take_bypass) begin
            if2id_pipeline_data <= {ibus_readdata, pc_head};
`ifdef IF_MISALIGN_EXC_EN
        end else if (exc_take) begin
            if2id_pipeline_data <= {NOP_INSTR, pc_q};
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a queue-based model
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall = 1'b0;
    logic        if_flush = 1'b0;
    logic        branch_take = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        trap_take = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_waitrequest = 1'b0;
    logic        ibus_readdatavalid = 1'b0;
    logic [31:0] ibus_readdata = '0;
    if2id_pipeline_ctrl_t ctrl;
    if2id_pipeline_data_t data;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0), .FETCH_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_stall            (if_stall),
        .if_flush            (if_flush),
        .branch_take         (branch_take),
        .branch_pc           (branch_pc),
        .trap_take           (trap_take),
        .trap_pc             (trap_pc),
        .ibus_read           (ibus_read),
        .ibus_address        (ibus_address),
        .ibus_waitrequest    (ibus_waitrequest),
        .ibus_readdatavalid  (ibus_readdatavalid),
        .ibus_readdata       (ibus_readdata),
        .if2id_pipeline_ctrl (ctrl),
        .if2id_pipeline_data (data)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    req_t        bus_q[$];
    item_t       pending[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          out_cnt = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_instr = '0;
    logic [31:0] model_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare the IF/ID register, drive inputs, check the bus request, advance the model.
    task automatic step(input bit r, input bit st, input bit fl, input bit br, input bit tr,
                        input logic [31:0] bpc, input logic [31:0] tpc, input bit wr, input bit rnd);
        req_t  head;
        item_t it;
        bit    rdv;
        bit    live;
        bit    acc;
        bit    exp_read;
        @(negedge clk);
        check("if2id_valid", {31'b0, ctrl.valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("if2id_pc", data.pc, exp_pc);
            check("if2id_instr", data.instruction, exp_instr);
        end
        rst = r;
        if_stall = st;
        if_flush = fl;
        branch_take = br;
        trap_take = tr;
        branch_pc = bpc;
        trap_pc = tpc;
        ibus_waitrequest = wr;
        rdv = (bus_q.size() > 0) && (bus_q[0].ready <= cyc) && (!rnd || $urandom_range(0, 3) != 0);
        ibus_readdatavalid = rdv;
        ibus_readdata = rdv ? mem_word(bus_q[0].addr) : $urandom;
        #1;
        exp_read = !r && !(br || tr) && ((bus_q.size() + pending.size()) < DEPTH);
        check("ibus_read", {31'b0, ibus_read}, {31'b0, exp_read});
        if (exp_read) check("ibus_address", ibus_address, model_pc);
        acc = exp_read && !wr;
        if (r) begin
            bus_q.delete();
            pending.delete();
            exp_valid = 1'b0;
            model_pc = 32'h0;
            epoch++;
        end else begin
            live = 1'b0;
            if (rdv) begin
                head = bus_q.pop_front();
                live = (head.epoch == epoch);
            end
            if (acc) begin
                bus_q.push_back('{model_pc, epoch, cyc + 1 + (rnd ? int'($urandom_range(0, 3)) : 0)});
                model_pc += 32'd4;
            end
            if (br || tr) begin
                model_pc = (tr ? tpc : bpc) & ~32'h3;
                pending.delete();
                epoch++;
                exp_valid = 1'b0;
            end else begin
                if (live) pending.push_back('{head.addr, mem_word(head.addr)});
                if (fl) begin
                    exp_valid = 1'b0;
                end else if (!st) begin
                    if (pending.size() > 0) begin
                        it = pending.pop_front();
                        exp_valid = 1'b1;
                        exp_pc = it.pc;
                        exp_instr = it.instr;
                        out_cnt++;
                    end else begin
                        exp_valid = 1'b0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit wr);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, wr, 1'b0);
    endtask

    task automatic random_steps(input int n);
        int          x;
        logic [31:0] bpc;
        logic [31:0] tpc;
        for (int i = 0; i < n; i++) begin
            x = int'($urandom_range(0, 49));
            bpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tpc = $urandom;
            step(1'b0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, x < 2, x == 2 || x == 3,
                 bpc, tpc, $urandom_range(0, 2) == 0, 1'b1);
        end
    endtask

    initial begin
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        check("reset_valid", {31'b0, ctrl.valid}, 32'd0);
        check("reset_read", {31'b0, ibus_read}, 32'd0);

        idle(1'b0);
        check("first_addr", ibus_address, 32'h0);
        idle(1'b0);
        check("second_addr", ibus_address, 32'h4);
        idle(1'b0);
        check("third_addr", ibus_address, 32'h8);
        check("first_out_valid", {31'b0, ctrl.valid}, 32'd1);
        check("first_out_pc", data.pc, 32'h0);
        check("first_out_instr", data.instruction, 32'h1357_9BDF);
        idle(1'b0);
        check("second_out_instr", data.instruction, 32'h1357_9BDB);

        repeat (3) begin
            idle(1'b1);
            check("wait_hold_addr", ibus_address, 32'h10);
            check("wait_hold_read", {31'b0, ibus_read}, 32'd1);
        end
        idle(1'b0);
        check("wait_accept_addr", ibus_address, 32'h10);

        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, '0, 1'b0, 1'b0);
        idle(1'b0);
        check("branch_addr", ibus_address, 32'h100);
        check("branch_gap1", {31'b0, ctrl.valid}, 32'd0);
        idle(1'b0);
        check("branch_gap2", {31'b0, ctrl.valid}, 32'd0);
        idle(1'b0);
        check("branch_n3_valid", {31'b0, ctrl.valid}, 32'd1);
        check("branch_n3_pc", data.pc, 32'h100);
        check("branch_n3_instr", data.instruction, 32'h1357_9ADF);
        repeat (2) idle(1'b0);

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h80, 1'b0, 1'b0);
        idle(1'b0);
        check("trap_prio_addr", ibus_address, 32'h80);
        repeat (2) idle(1'b0);
        check("trap_prio_pc", data.pc, 32'h80);
        check("trap_prio_instr", data.instruction, 32'h1357_9B5F);

        random_steps(3000);

        for (int i = 0; i < 40 && bus_q.size() > 0; i++) idle(1'b1);
        check("drain_bus", bus_q.size(), 32'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        check("mid_reset_valid", {31'b0, ctrl.valid}, 32'd0);
        check("mid_reset_read", {31'b0, ibus_read}, 32'd0);
        idle(1'b0);
        check("mid_reset_addr", ibus_address, 32'h0);

        random_steps(2000);
        check("stream_progress", {31'b0, out_cnt > 500}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
